// File: rtl/tron_pkg.sv
// Shared types for the light-cycle game blocks.
//   GS_PLAY     : Game_State encoding of the PLAY phase
//   coord_t     : bike cell coordinate (8 bits)
//   cell_addr_t : occupancy map address (14 bits)
//   state_t     : trail_collision FSM states
//   cell_addr() : Y*W+X using 32-bit arithmetic before narrowing
package tron_pkg;

   localparam logic [2:0] GS_PLAY = 3'b010;

   typedef logic [7:0]  coord_t;
   typedef logic [13:0] cell_addr_t;

   typedef enum logic [2:0] {
      ST_CLEAR,
      ST_IDLE,
      ST_RD_B,
      ST_RD_R,
      ST_CHK,
      ST_WR_B,
      ST_WR_R,
      ST_REPORT
   } state_t;

   function automatic cell_addr_t cell_addr(input coord_t x, input coord_t y,
                                            input int unsigned w);
      int unsigned a;
      a = 32'(y) * w + 32'(x);
      return cell_addr_t'(a);
   endfunction

endpackage

// File: rtl/occupancy_ram.sv
// Single-port 1-bit synchronous RAM holding the trail occupancy map.
// Read data appears one cycle after the address; writes land on the same edge.
// Addresses at or above DEPTH never write and read back 0.
//   Clk   : clock
//   addr  : cell address
//   wdata : bit to write
//   we    : write enable
//   rdata : registered read data
module occupancy_ram #(
   parameter int unsigned DEPTH = 12544,
   parameter int unsigned AW    = 14
) (
   input  logic          Clk,
   input  logic [AW-1:0] addr,
   input  logic          wdata,
   input  logic          we,
   output logic          rdata
);

   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

   logic mem [DEPTH];

   always_ff @(posedge Clk) begin
      if (we && addr <= LAST) begin
         mem[addr] <= wdata;
      end
      rdata <= (addr <= LAST) ? mem[addr] : 1'b0;
   end

endmodule

// File: rtl/trail_collision.sv
// Light-cycle collision detector. Once per frame-strobe rising edge (in PLAY)
// it checks both bikes' cells against the occupancy map, the arena bounds and
// (optionally) each other, then marks both cells occupied.
//   Clk            : system clock
//   Reset_n        : synchronous active-low reset
//   frame_clk      : frame strobe, rising edge starts a check
//   Game_State     : game phase, GS_PLAY enables checks
//   Blue_X/Blue_Y  : blue bike cell
//   Red_X/Red_Y    : red bike cell
//   collision_blue : sticky blue crash flag
//   collision_red  : sticky red crash flag
//   result_valid   : one-cycle pulse when a check completes
//   busy           : high in every state but IDLE
// Build option: TRAIL_COLL_HEADON_EN makes a shared in-bounds cell a draw.
//
// state     | meaning
// CLEAR     | sweep zeros through the map, one cell per cycle
// IDLE      | wait for a frame edge in PLAY
// RD_B      | read blue cell
// RD_R      | read red cell, capture blue occupancy
// CHK       | capture red occupancy, decide crashes
// WR_B      | mark blue cell (in bounds only)
// WR_R      | mark red cell, fold crashes into flags
// REPORT    | result_valid pulse
module trail_collision
   import tron_pkg::*;
#(
   parameter int unsigned GRID_W = 112,
   parameter int unsigned GRID_H = 112
) (
   input  logic       Clk,
   input  logic       Reset_n,
   input  logic       frame_clk,
   input  logic [2:0] Game_State,
   input  logic [7:0] Blue_X,
   input  logic [7:0] Blue_Y,
   input  logic [7:0] Red_X,
   input  logic [7:0] Red_Y,
   output logic       collision_blue,
   output logic       collision_red,
   output logic       result_valid,
   output logic       busy
);

   localparam int unsigned DEPTH     = GRID_W * GRID_H;
   localparam cell_addr_t  LAST_CELL = cell_addr_t'(DEPTH - 1);
   localparam coord_t      GW        = coord_t'(GRID_W);
   localparam coord_t      GH        = coord_t'(GRID_H);

   state_t     state, state_n;
   logic       frame_clk_d, play_d;
   coord_t     bx, by, rx, ry, pbx, pby, prx, pry;
   logic       prev_ok, occ_b, crash_b, crash_r;
   cell_addr_t clr_cnt, addr_b, addr_r, ram_addr;
   logic       ram_we, ram_wdata, ram_rdata;
   logic       rise, in_play, play_exit, b_in, r_in, headon, hit_b, hit_r;

   always_comb begin
      rise      = frame_clk & ~frame_clk_d;
      in_play   = (Game_State == GS_PLAY);
      play_exit = play_d & ~in_play;
      b_in      = (bx < GW) && (by < GH);
      r_in      = (rx < GW) && (ry < GH);
      addr_b    = cell_addr(bx, by, GRID_W);
      addr_r    = cell_addr(rx, ry, GRID_W);
`ifdef TRAIL_COLL_HEADON_EN
      headon    = b_in && (bx == rx) && (by == ry);
`else
      headon    = 1'b0;
`endif
      // A bike that has not moved since the last check sits on its own mark.
      hit_b     = occ_b & ~(prev_ok && (bx == pbx) && (by == pby));
      hit_r     = ram_rdata & ~(prev_ok && (rx == prx) && (ry == pry));
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) state <= ST_CLEAR;
      else          state <= state_n;
   end

   always_comb begin
      state_n   = state;
      ram_addr  = addr_b;
      ram_we    = 1'b0;
      ram_wdata = 1'b0;
      case (state)
         ST_CLEAR: begin
            ram_addr = clr_cnt;
            ram_we   = 1'b1;
            if (clr_cnt == LAST_CELL) state_n = ST_IDLE;
         end
         ST_IDLE:   if (rise && in_play) state_n = ST_RD_B;
         ST_RD_B:   state_n = ST_RD_R;
         ST_RD_R: begin
            ram_addr = addr_r;
            state_n  = ST_CHK;
         end
         ST_CHK:    state_n = ST_WR_B;
         ST_WR_B: begin
            ram_we    = b_in;
            ram_wdata = 1'b1;
            state_n   = ST_WR_R;
         end
         ST_WR_R: begin
            ram_addr  = addr_r;
            ram_we    = r_in;
            ram_wdata = 1'b1;
            state_n   = ST_REPORT;
         end
         ST_REPORT: state_n = ST_IDLE;
         default:   state_n = ST_CLEAR;
      endcase
      if (play_exit && state != ST_CLEAR) state_n = ST_CLEAR;
      // Reset must not let a pending mark land on the map.
      if (!Reset_n) ram_we = 1'b0;
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         frame_clk_d    <= 1'b0;
         play_d         <= 1'b0;
         clr_cnt        <= '0;
         bx             <= '0;
         by             <= '0;
         rx             <= '0;
         ry             <= '0;
         pbx            <= '0;
         pby            <= '0;
         prx            <= '0;
         pry            <= '0;
         prev_ok        <= 1'b0;
         occ_b          <= 1'b0;
         crash_b        <= 1'b0;
         crash_r        <= 1'b0;
         collision_blue <= 1'b0;
         collision_red  <= 1'b0;
      end else begin
         frame_clk_d <= frame_clk;
         play_d      <= in_play;
         case (state)
            ST_CLEAR: clr_cnt <= clr_cnt + cell_addr_t'(1);
            ST_IDLE: begin
               if (rise && in_play) begin
                  bx <= Blue_X;
                  by <= Blue_Y;
                  rx <= Red_X;
                  ry <= Red_Y;
               end
            end
            ST_RD_R: occ_b <= ram_rdata;
            ST_CHK: begin
               crash_b <= ~b_in | hit_b | headon;
               crash_r <= ~r_in | hit_r | headon;
            end
            // Flags land here so they are visible in the REPORT cycle.
            ST_WR_R: begin
               collision_blue <= collision_blue | crash_b;
               collision_red  <= collision_red | crash_r;
               pbx            <= bx;
               pby            <= by;
               prx            <= rx;
               pry            <= ry;
               prev_ok        <= 1'b1;
            end
            default: ;
         endcase
         if (play_exit && state != ST_CLEAR) begin
            clr_cnt        <= '0;
            collision_blue <= 1'b0;
            collision_red  <= 1'b0;
            prev_ok        <= 1'b0;
         end
      end
   end

   assign result_valid = (state == ST_REPORT);
   assign busy         = (state != ST_IDLE);

   occupancy_ram #(
      .DEPTH (DEPTH),
      .AW    (14)
   ) u_occupancy_ram (
      .Clk   (Clk),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .we    (ram_we),
      .rdata (ram_rdata)
   );

endmodule

// File: tb/tb_trail_collision.sv
// Bench for trail_collision: directed frame table, hand-written multi-cycle
// sequences (PLAY exit mid-check, reset mid-check, dropped edges) and random
// frames scored against an occupancy-map model.
module tb_trail_collision;

   localparam int GW = 112;
   localparam int GH = 112;
   localparam int CLEAR_CYCLES = GW * GH;
`ifdef TRAIL_COLL_HEADON_EN
   localparam bit HE = 1'b1;
`else
   localparam bit HE = 1'b0;
`endif

   logic       Clk = 1'b0;
   logic       Reset_n;
   logic       frame_clk;
   logic [2:0] Game_State;
   logic [7:0] Blue_X, Blue_Y, Red_X, Red_Y;
   logic       collision_blue, collision_red, result_valid, busy;

   int n_pass  = 0;
   int n_total = 0;

   // reference model state
   bit       mmap [GW*GH];
   bit       m_b, m_r, m_prev_ok;
   logic [7:0] m_pbx, m_pby, m_prx, m_pry;

   typedef struct {
      logic [7:0] bx, by, rx, ry;
      bit         extra;
      bit         eb, er;
   } vec_t;

   vec_t vecs [13];
   localparam int NA = 6;

   always #10 Clk = ~Clk;

   trail_collision #(.GRID_W(GW), .GRID_H(GH)) dut (
      .Clk            (Clk),
      .Reset_n        (Reset_n),
      .frame_clk      (frame_clk),
      .Game_State     (Game_State),
      .Blue_X         (Blue_X),
      .Blue_Y         (Blue_Y),
      .Red_X          (Red_X),
      .Red_Y          (Red_Y),
      .collision_blue (collision_blue),
      .collision_red  (collision_red),
      .result_valid   (result_valid),
      .busy           (busy)
   );

   initial begin
      #(20 * 200000);
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic model_clear();
      for (int i = 0; i < GW * GH; i++) mmap[i] = 1'b0;
      m_b = 1'b0;
      m_r = 1'b0;
      m_prev_ok = 1'b0;
   endtask

   task automatic model_frame(input logic [7:0] bx, by, rx, ry);
      int  xb, yb, xr, yr;
      bit  inb, inr, cb, cr;
      xb = int'(bx); yb = int'(by); xr = int'(rx); yr = int'(ry);
      inb = (xb < GW) && (yb < GH);
      inr = (xr < GW) && (yr < GH);
      cb = !inb;
      cr = !inr;
      if (inb && mmap[yb*GW+xb] && !(m_prev_ok && bx == m_pbx && by == m_pby)) cb = 1'b1;
      if (inr && mmap[yr*GW+xr] && !(m_prev_ok && rx == m_prx && ry == m_pry)) cr = 1'b1;
      if (HE && inb && bx == rx && by == ry) begin
         cb = 1'b1;
         cr = 1'b1;
      end
      if (inb) mmap[yb*GW+xb] = 1'b1;
      if (inr) mmap[yr*GW+xr] = 1'b1;
      m_b = m_b | cb;
      m_r = m_r | cr;
      m_pbx = bx; m_pby = by; m_prx = rx; m_pry = ry;
      m_prev_ok = 1'b1;
   endtask

   task automatic count_busy(output int n);
      n = 0;
      while (busy === 1'b1 && n < 20000) begin
         n++;
         @(negedge Clk);
      end
   endtask

   // One frame: rise at a negedge, expect result_valid only 6 edges later.
   // extra re-raises frame_clk while the check is in RD_R; that edge is dropped.
   task automatic run_frame(input logic [7:0] bx, by, rx, ry, input bit extra,
                            input bit eb, input bit er, input string tag);
      int   first_k, rv_cnt;
      logic fb, fr;
      first_k = 0; rv_cnt = 0; fb = 1'bx; fr = 1'bx;
      @(negedge Clk);
      Blue_X = bx; Blue_Y = by; Red_X = rx; Red_Y = ry;
      frame_clk = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         @(posedge Clk);
         @(negedge Clk);
         if (k == 1) frame_clk = 1'b0;
         if (extra && k == 2) frame_clk = 1'b1;
         if (extra && k == 3) frame_clk = 1'b0;
         if (result_valid === 1'b1) begin
            rv_cnt++;
            if (first_k == 0) first_k = k;
         end
         if (k == 6) begin
            fb = collision_blue;
            fr = collision_red;
         end
      end
      check($sformatf("%s rv_at", tag), first_k, 6);
      check($sformatf("%s rv_count", tag), rv_cnt, 1);
      check($sformatf("%s blue", tag), {31'd0, fb}, {31'd0, eb});
      check($sformatf("%s red", tag), {31'd0, fr}, {31'd0, er});
      check($sformatf("%s idle", tag), {31'd0, busy}, 0);
   endtask

   initial begin
      int n, cnt;
      logic [7:0] rbx, rby, rrx, rry;

      vecs[0]  = '{8'd10, 8'd10, 8'd50,  8'd50, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{8'd11, 8'd10, 8'd49,  8'd50, 1'b1, 1'b0, 1'b0};
      vecs[2]  = '{8'd10, 8'd10, 8'd48,  8'd50, 1'b0, 1'b1, 1'b0};
      vecs[3]  = '{8'd12, 8'd10, 8'd47,  8'd50, 1'b0, 1'b1, 1'b0};
      vecs[4]  = '{8'd13, 8'd10, 8'd46,  8'd50, 1'b0, 1'b1, 1'b0};
      vecs[5]  = '{8'd14, 8'd10, 8'd45,  8'd50, 1'b0, 1'b1, 1'b0};
      vecs[6]  = '{8'd10, 8'd10, 8'd50,  8'd50, 1'b0, 1'b0, 1'b0};
      vecs[7]  = '{8'd20, 8'd20, 8'd111, 8'd50, 1'b0, 1'b0, 1'b0};
      vecs[8]  = '{8'd60, 8'd60, 8'd60,  8'd60, 1'b0, HE,   HE};
      vecs[9]  = '{8'd61, 8'd60, 8'd60,  8'd60, 1'b0, HE,   HE};
      vecs[10] = '{8'd5,  8'd5,  8'd112, 8'd50, 1'b0, HE,   1'b1};
      vecs[11] = '{8'd0,  8'd51, 8'd112, 8'd50, 1'b0, HE,   1'b1};
      vecs[12] = '{8'd60, 8'd60, 8'd112, 8'd50, 1'b0, 1'b1, 1'b1};

      Reset_n = 1'b0; frame_clk = 1'b0; Game_State = 3'b000;
      Blue_X = 0; Blue_Y = 0; Red_X = 0; Red_Y = 0;
      model_clear();
      @(posedge Clk); @(posedge Clk); @(negedge Clk);
      check("reset rv", {31'd0, result_valid}, 0);
      check("reset blue", {31'd0, collision_blue}, 0);
      check("reset red", {31'd0, collision_red}, 0);
      check("reset busy", {31'd0, busy}, 1);
      Reset_n = 1'b1;
      count_busy(n);
      check("initial sweep cycles", n, CLEAR_CYCLES);

      // frame edge outside PLAY is ignored
      frame_clk = 1'b1;
      cnt = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge Clk);
         frame_clk = 1'b0;
         if (busy !== 1'b0 || result_valid !== 1'b0) cnt++;
      end
      check("non-play edge ignored", cnt, 0);

      Game_State = 3'b010;
      for (int i = 0; i < NA; i++)
         run_frame(vecs[i].bx, vecs[i].by, vecs[i].rx, vecs[i].ry, vecs[i].extra,
                   vecs[i].eb, vecs[i].er, $sformatf("vec%0d", i));

      // leave PLAY while the check sits in RD_R
      @(negedge Clk);
      Blue_X = 8'd30; Blue_Y = 8'd30; Red_X = 8'd70; Red_Y = 8'd70;
      frame_clk = 1'b1;
      cnt = 0;
      for (int k = 1; k <= 3; k++) begin
         @(posedge Clk); @(negedge Clk);
         if (k == 1) frame_clk = 1'b0;
         if (k == 2) Game_State = 3'b001;
         if (result_valid === 1'b1) cnt++;
      end
      check("exit blue", {31'd0, collision_blue}, 0);
      check("exit red", {31'd0, collision_red}, 0);
      count_busy(n);
      check("exit sweep cycles", n, CLEAR_CYCLES);
      check("exit no report", cnt, 0);
      Game_State = 3'b010;
      model_clear();

      for (int i = NA; i < 13; i++)
         run_frame(vecs[i].bx, vecs[i].by, vecs[i].rx, vecs[i].ry, vecs[i].extra,
                   vecs[i].eb, vecs[i].er, $sformatf("vec%0d", i));

      // random episodes against the model, each from a freshly cleared map
      for (int ep = 0; ep < 2; ep++) begin
         @(negedge Clk);
         Game_State = 3'b001;
         @(negedge Clk);
         count_busy(n);
         check($sformatf("ep%0d sweep cycles", ep), n, CLEAR_CYCLES);
         check($sformatf("ep%0d flags cleared", ep), {30'd0, collision_blue, collision_red}, 0);
         Game_State = 3'b010;
         model_clear();
         for (int f = 0; f < 30; f++) begin
            rbx = ($urandom_range(0, 7) == 0) ? 8'(109 + $urandom_range(0, 5)) : 8'($urandom_range(0, 4));
            rby = ($urandom_range(0, 9) == 0) ? 8'(110 + $urandom_range(0, 3)) : 8'($urandom_range(0, 4));
            rrx = ($urandom_range(0, 7) == 0) ? 8'(109 + $urandom_range(0, 5)) : 8'($urandom_range(0, 4));
            rry = ($urandom_range(0, 9) == 0) ? 8'(110 + $urandom_range(0, 3)) : 8'($urandom_range(0, 4));
            model_frame(rbx, rby, rrx, rry);
            run_frame(rbx, rby, rrx, rry, 1'($urandom_range(0, 1)), m_b, m_r,
                      $sformatf("ep%0d f%0d", ep, f));
         end
      end

      // reset in the middle of a check (during WR_B)
      @(negedge Clk);
      Blue_X = 8'd3; Blue_Y = 8'd3; Red_X = 8'd4; Red_Y = 8'd4;
      frame_clk = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         @(posedge Clk); @(negedge Clk);
         if (k == 1) frame_clk = 1'b0;
      end
      Reset_n = 1'b0;
      @(posedge Clk); @(negedge Clk);
      check("midreset busy", {31'd0, busy}, 1);
      check("midreset rv", {31'd0, result_valid}, 0);
      check("midreset flags", {30'd0, collision_blue, collision_red}, 0);
      Reset_n = 1'b1;
      count_busy(n);
      check("midreset sweep cycles", n, CLEAR_CYCLES);
      model_clear();
      model_frame(8'd3, 8'd3, 8'd4, 8'd4);
      run_frame(8'd3, 8'd3, 8'd4, 8'd4, 1'b0, m_b, m_r, "post-reset");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
